// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio codec types and defaults for the ADC and DAC paths
package audio_pkg;

    localparam int AUDIO_ADDR_W = 20;
    localparam int AUDIO_DATA_W = 16;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT       = 3'd1,
        S_READ_LEFT  = 3'd2,
        S_READ_RIGHT = 3'd3,
        S_WRITE      = 3'd4,
        S_DONE       = 3'd5
    } rec_state_t;

endpackage

// File: rtl/adc_recorder_if.sv
// rtl/adc_recorder_if.sv - SRAM write bus driven by the recorder
interface adc_recorder_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              o_SRAM_WE_N;
    logic [ADDR_W-1:0] o_SRAM_ADDR;
    logic [DATA_W-1:0] o_SRAM_DATA;

    modport master (
        output o_SRAM_WE_N,
        output o_SRAM_ADDR,
        output o_SRAM_DATA
    );

    modport slave (
        input o_SRAM_WE_N,
        input o_SRAM_ADDR,
        input o_SRAM_DATA
    );
endinterface

// File: rtl/i2s_rx_shift.sv
// rtl/i2s_rx_shift.sv - MSB-first serial word capture with 4-bit bit counter
module i2s_rx_shift #(
    parameter int W = 16
) (
    input  logic         i_BCLK,
    input  logic         i_rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic         sdata,
    output logic [W-1:0] word,
    output logic         done
);
    // Only W-1 bits are stored: the final bit is taken straight from sdata
    // so the complete word is available in the cycle it finishes.
    logic [W-2:0] sr;
    logic [3:0]   bit_cnt;

    assign word = {sr, sdata};
    assign done = en && (bit_cnt == 4'(W - 1));

    // Shift one bit per enabled cycle; counter wraps to zero after the last bit
    always_ff @(posedge i_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (en) begin
            sr      <= word[W-2:0];
            bit_cnt <= done ? 4'd0 : bit_cnt + 4'd1;
        end
    end
endmodule

// File: rtl/adc_recorder.sv
// rtl/adc_recorder.sv - codec ADC frame capture into an SRAM region; ADC_MONO_AVG_EN stores (L+R)>>>1
module adc_recorder
    import audio_pkg::*;
#(
    parameter int ADDR_W = AUDIO_ADDR_W,
    parameter int DATA_W = AUDIO_DATA_W
) (
    input  logic              i_BCLK,
    input  logic              i_rst_n,
    input  logic              i_record,
    input  logic [ADDR_W-1:0] i_start_pos,
    input  logic [ADDR_W-1:0] i_end_pos,
    input  logic              i_ADCLRCK,
    input  logic              i_ADCDAT,
    adc_recorder_if.master    sram,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_last_pos,
    output logic [2:0]        o_state
);
    rec_state_t        state, state_n;
    logic              lrck_q;
    logic              left_held;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] left_q;
    logic [DATA_W-1:0] sample_q;
    logic [DATA_W-1:0] frame_sample;
    logic [DATA_W-1:0] sh_word;
    logic              sh_done;
    logic              sh_en;
    logic              lrck_fall, lrck_rise, at_end;

    assign lrck_fall = lrck_q & ~i_ADCLRCK;
    assign lrck_rise = ~lrck_q & i_ADCLRCK;
    assign at_end    = (addr_q >= i_end_pos);
    assign sh_en     = (state == S_READ_LEFT) || (state == S_READ_RIGHT);

    i2s_rx_shift #(.W(DATA_W)) u_shift (
        .i_BCLK  (i_BCLK),
        .i_rst_n (i_rst_n),
        .clr     (state == S_IDLE),
        .en      (sh_en),
        .sdata   (i_ADCDAT),
        .word    (sh_word),
        .done    (sh_done)
    );

`ifdef ADC_MONO_AVG_EN
    // One extra bit of headroom makes the sum exact; halving brings it back in range.
    logic [DATA_W:0] mono_sum;
    assign mono_sum     = {left_q[DATA_W-1], left_q} + {sh_word[DATA_W-1], sh_word};
    assign frame_sample = DATA_W'(mono_sum >> 1);
`else
    assign frame_sample = left_q;
`endif

    assign sram.o_SRAM_WE_N = (state != S_WRITE);
    assign sram.o_SRAM_ADDR = addr_q;
    assign sram.o_SRAM_DATA = sample_q;
    assign o_done           = (state == S_DONE);
    assign o_state          = state;

    // State register
    always_ff @(posedge i_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_n;
    end

    // Next-state: frame sequencing, abort on record drop, stop at region end
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:       if (i_record) state_n = S_WAIT;
            S_WAIT: begin
                if (!i_record)                    state_n = S_DONE;
                else if (lrck_fall)               state_n = S_READ_LEFT;
                else if (lrck_rise && left_held)  state_n = S_READ_RIGHT;
            end
            S_READ_LEFT: begin
                if (!i_record)    state_n = S_DONE;
                else if (sh_done) state_n = S_WAIT;
            end
            S_READ_RIGHT: begin
                if (!i_record)    state_n = S_DONE;
                else if (sh_done) state_n = S_WRITE;
            end
            S_WRITE:      state_n = (!i_record || at_end) ? S_DONE : S_WAIT;
            S_DONE:       state_n = S_IDLE;
            default:      state_n = S_IDLE;
        endcase
    end

    // Datapath: word clock history, held left word, sample, address and last position
    always_ff @(posedge i_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lrck_q     <= 1'b0;
            left_held  <= 1'b0;
            addr_q     <= '0;
            left_q     <= '0;
            sample_q   <= '0;
            o_last_pos <= '0;
        end else begin
            lrck_q <= i_ADCLRCK;
            case (state)
                S_IDLE: begin
                    addr_q    <= i_start_pos;
                    left_held <= 1'b0;
                end
                S_WAIT: begin
                    if (lrck_fall) left_held <= 1'b0;
                end
                S_READ_LEFT: begin
                    if (i_record && sh_done) begin
                        left_q    <= sh_word;
                        left_held <= 1'b1;
                    end
                end
                S_READ_RIGHT: begin
                    if (i_record && sh_done) begin
                        sample_q  <= frame_sample;
                        left_held <= 1'b0;
                    end
                end
                S_WRITE: begin
                    o_last_pos <= addr_q;
                    if (state_n == S_WAIT) addr_q <= addr_q + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_recorder.sv
// tb/tb_adc_recorder.sv - self-checking bench for adc_recorder with a frame-level reference model
module tb_adc_recorder;
    localparam bit MONO = `ifdef ADC_MONO_AVG_EN 1'b1 `else 1'b0 `endif;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        record;
    logic [19:0] st_pos, end_pos;
    logic        adc_lrck, adc_dat;
    logic        o_done;
    logic [19:0] o_last_pos;
    logic [2:0]  o_state;

    adc_recorder_if #(.ADDR_W(20), .DATA_W(16)) sram_bus ();

    adc_recorder #(.ADDR_W(20), .DATA_W(16)) dut (
        .i_BCLK      (clk),
        .i_rst_n     (rst_n),
        .i_record    (record),
        .i_start_pos (st_pos),
        .i_end_pos   (end_pos),
        .i_ADCLRCK   (adc_lrck),
        .i_ADCDAT    (adc_dat),
        .sram        (sram_bus),
        .o_done      (o_done),
        .o_last_pos  (o_last_pos),
        .o_state     (o_state)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int failed = 0;
    int done_cnt;
    logic [31:0] wr_addr_q[$], wr_data_q[$];
    logic [31:0] exp_addr_q[$], exp_data_q[$];
    logic [31:0] exp_last;
    logic [15:0] fl[8], fr[8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_sample(input logic [15:0] l, input logic [15:0] r);
        int s;
        s = int'(signed'(l)) + int'(signed'(r));
        return MONO ? 16'(s >>> 1) : l;
    endfunction

    // Frame layout: 20 cycles per half, LRCK low for left, MSB one cycle after the edge.
    function automatic logic [1:0] frame_bits(input logic [15:0] l, input logic [15:0] r, input int c);
        int h;
        logic [15:0] w;
        logic d;
        h = c % 20;
        w = (c < 20) ? l : r;
        d = (h >= 1 && h <= 16) ? w[4'(16 - h)] : 1'($urandom % 2);
        return {(c >= 20), d};
    endfunction

    task automatic step(input logic lr, input logic d);
        @(negedge clk);
        if (sram_bus.o_SRAM_WE_N === 1'b0) begin
            wr_addr_q.push_back(32'(sram_bus.o_SRAM_ADDR));
            wr_data_q.push_back(32'(sram_bus.o_SRAM_DATA));
        end
        if (o_done === 1'b1) begin
            done_cnt++;
            record = 1'b0;
        end
        adc_lrck = lr;
        adc_dat  = d;
    endtask

    task automatic clear_obs();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt = 0;
    endtask

    task automatic build_expect(input int nframes, input int abort_f, input bit late);
        logic [31:0] a;
        exp_addr_q.delete();
        exp_data_q.delete();
        a = 32'(st_pos);
        exp_last = 32'(o_last_pos);
        for (int f = 0; f < nframes; f++) begin
            if (late && f == 0) continue;
            if (f == abort_f) break;
            exp_addr_q.push_back(a);
            exp_data_q.push_back(32'(exp_sample(fl[f], fr[f])));
            exp_last = a;
            if (a >= 32'(end_pos)) break;
            a = a + 1;
        end
    endtask

    task automatic do_record(input int nframes, input int abort_f, input bit late);
        logic [1:0] b;
        if (!late) begin
            record = 1'b1;
            repeat (4) step(1'b1, 1'b0);
        end
        for (int f = 0; f < nframes; f++) begin
            for (int c = 0; c < 40; c++) begin
                if (late && f == 0 && c == 26) record = 1'b1;
                if (f == abort_f && c == 29) record = 1'b0;
                b = frame_bits(fl[f], fr[f], c);
                step(b[1], b[0]);
            end
        end
        repeat (8) step(1'b1, 1'b0);
        record = 1'b0;
        repeat (4) step(1'b1, 1'b0);
    endtask

    task automatic verify(input string tag);
        logic [31:0] oa, od;
        check({tag, ".nwr"}, 32'(wr_addr_q.size()), 32'(exp_addr_q.size()));
        for (int i = 0; i < exp_addr_q.size(); i++) begin
            oa = (i < wr_addr_q.size()) ? wr_addr_q[i] : 'x;
            od = (i < wr_data_q.size()) ? wr_data_q[i] : 'x;
            check($sformatf("%s.addr%0d", tag, i), oa, exp_addr_q[i]);
            check($sformatf("%s.data%0d", tag, i), od, exp_data_q[i]);
        end
        check({tag, ".done"}, 32'(done_cnt), 32'd1);
        check({tag, ".last"}, 32'(o_last_pos), exp_last);
        check({tag, ".state"}, 32'(o_state), 32'd0);
    endtask

    task automatic scenario(input string tag, input logic [19:0] s, input logic [19:0] e,
                            input int nframes, input int abort_f, input bit late);
        st_pos  = s;
        end_pos = e;
        clear_obs();
        build_expect(nframes, abort_f, late);
        do_record(nframes, abort_f, late);
        verify(tag);
    endtask

    initial begin
        rst_n    = 1'b0;
        record   = 1'b0;
        adc_lrck = 1'b1;
        adc_dat  = 1'b0;
        st_pos   = '0;
        end_pos  = '0;
        done_cnt = 0;
        #12;
        check("rst.state", 32'(o_state), 32'd0);
        check("rst.we_n", 32'(sram_bus.o_SRAM_WE_N), 32'd1);
        check("rst.addr", 32'(sram_bus.o_SRAM_ADDR), 32'd0);
        check("rst.data", 32'(sram_bus.o_SRAM_DATA), 32'd0);
        check("rst.done", 32'(o_done), 32'd0);
        check("rst.last", 32'(o_last_pos), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b1, 1'b0);

        // Three identical frames fill 0x10..0x12; the fourth must be ignored
        for (int i = 0; i < 4; i++) begin fl[i] = 16'h1234; fr[i] = 16'h1234; end
        scenario("basic", 20'h00010, 20'h00012, 4, -1, 1'b0);

        // Averaging boundaries (or left-only without the macro)
        fl[0] = 16'h7FFF; fr[0] = 16'h7FFF;
        fl[1] = 16'h8000; fr[1] = 16'h7FFF;
        fl[2] = 16'h8000; fr[2] = 16'h8000;
        scenario("avg", 20'h00300, 20'h00302, 3, -1, 1'b0);

        // Random samples at the top of the address space, no wrap
        for (int i = 0; i < 8; i++) begin fl[i] = 16'($urandom); fr[i] = 16'($urandom); end
        scenario("top", 20'hFFFFC, 20'hFFFFF, 5, -1, 1'b0);

        for (int i = 0; i < 8; i++) begin fl[i] = 16'($urandom); fr[i] = 16'($urandom); end
        scenario("rand", 20'($urandom_range(0, 20'hFF000)), 20'hFF800, 3, -1, 1'b0);

        // Record dropped mid right word of the second frame
        for (int i = 0; i < 8; i++) begin fl[i] = 16'($urandom); fr[i] = 16'($urandom); end
        scenario("abort", 20'h00400, 20'h00405, 3, 1, 1'b0);

        // Record raised mid right word: that frame is skipped
        for (int i = 0; i < 8; i++) begin fl[i] = 16'($urandom); fr[i] = 16'($urandom); end
        scenario("late", 20'h00500, 20'h00501, 3, -1, 1'b1);

        // Reversed region writes a single word
        for (int i = 0; i < 8; i++) begin fl[i] = 16'($urandom); fr[i] = 16'($urandom); end
        scenario("rev", 20'h00005, 20'h00003, 2, -1, 1'b0);

        // Reset mid left word: immediate reset values, nothing written, clean restart
        st_pos  = 20'h00200;
        end_pos = 20'h00201;
        clear_obs();
        for (int i = 0; i < 8; i++) begin fl[i] = 16'($urandom); fr[i] = 16'($urandom); end
        record = 1'b1;
        repeat (4) step(1'b1, 1'b0);
        for (int c = 0; c < 9; c++) begin
            logic [1:0] b;
            b = frame_bits(16'hA5A5, 16'h5A5A, c);
            step(b[1], b[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        check("mrst.state", 32'(o_state), 32'd0);
        check("mrst.we_n", 32'(sram_bus.o_SRAM_WE_N), 32'd1);
        check("mrst.addr", 32'(sram_bus.o_SRAM_ADDR), 32'd0);
        check("mrst.data", 32'(sram_bus.o_SRAM_DATA), 32'd0);
        check("mrst.done", 32'(o_done), 32'd0);
        check("mrst.last", 32'(o_last_pos), 32'd0);
        record   = 1'b0;
        adc_lrck = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step(1'b1, 1'b0);
        check("mrst.nowr", 32'(wr_addr_q.size()), 32'd0);
        clear_obs();
        build_expect(2, -1, 1'b0);
        do_record(2, -1, 1'b0);
        verify("rearm");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/adc_recorder.md
ADC_RECORDER -- requirements
Module: adc_recorder

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, SRAM address width.
REQ-002 SHALL have parameter DATA_W, default 16, sample width per channel and SRAM word width.
REQ-003 SHALL have port i_BCLK  input  1  sole clock; all flops on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_record  input  1  level; high requests recording, low aborts.
REQ-006 SHALL have ports i_start_pos / i_end_pos  input  ADDR_W  first and last SRAM address of the recording region.
REQ-007 SHALL have ports i_ADCLRCK  input  1  codec word clock (low = left, high = right), and i_ADCDAT  input  1  codec serial data.
REQ-008 SHALL have ports o_SRAM_WE_N  output  1  active-low write strobe; o_SRAM_ADDR  output  ADDR_W; o_SRAM_DATA  output  DATA_W.
REQ-009 SHALL have ports o_done  output  1  one-cycle completion pulse; o_last_pos  output  ADDR_W  last address written; o_state  output  3  current state encoding.

Function
REQ-010 States SHALL be S_IDLE(0), S_WAIT(1), S_READ_LEFT(2), S_READ_RIGHT(3), S_WRITE(4), S_DONE(5); o_state SHALL equal the encoding.
REQ-011 S_IDLE: address register loads i_start_pos, bit counter clears; i_record=1 -> S_WAIT next cycle.
REQ-012 i_ADCLRCK SHALL be registered once; falling edge (prev 1, now 0) in S_WAIT -> S_READ_LEFT; rising edge -> S_READ_RIGHT only after a left word is held this frame, otherwise ignored.
REQ-013 S_READ_LEFT/RIGHT: shift i_ADCDAT in, MSB first, one bit per cycle starting the cycle after entry, 16 bits exactly; after bit 15 -> S_WAIT (left) or S_WRITE (right).
REQ-014 S_WRITE: for exactly one cycle o_SRAM_WE_N=0 with o_SRAM_ADDR = address register and o_SRAM_DATA = stored sample; o_SRAM_DATA SHALL be stable that whole cycle.
REQ-015 After S_WRITE: o_last_pos <= address; if address == i_end_pos -> S_DONE, else address <= address+1 and -> S_WAIT.
REQ-016 Address SHALL never exceed i_end_pos; no wrap-around; i_start_pos > i_end_pos SHALL write exactly one word at i_start_pos then finish.
REQ-017 S_DONE: o_done=1 for one cycle, -> S_IDLE.
REQ-018 i_record=0 in S_WAIT/S_READ_LEFT/S_READ_RIGHT SHALL abort to S_DONE without writing the partial frame; i_record=0 during S_WRITE SHALL still complete that write, then -> S_DONE.
REQ-019 o_SRAM_WE_N SHALL be 1 in every state other than S_WRITE.
REQ-020 o_last_pos SHALL hold its value through S_IDLE until the next completed write.

Reset
REQ-021 On i_rst_n=0, asynchronously: state S_IDLE, o_SRAM_WE_N=1, o_SRAM_ADDR=0, o_SRAM_DATA=0, o_done=0, o_last_pos=0, shift/bit counter=0, registered LRCK=0.
REQ-022 Reset asserted mid-frame SHALL discard partial data; no SRAM write SHALL occur in the cycle reset deasserts.

Configuration
REQ-023 With ADC_MONO_AVG_EN defined: stored sample = (signed L + signed R) >>> 1, computed at 17 bits, truncated to 16; never overflows.
REQ-024 Without ADC_MONO_AVG_EN: stored sample = left word; right word is shifted in (timing unchanged) and discarded.

Structure
REQ-025 State enum, ADDR_W/DATA_W defaults and state encodings SHALL live in shared package audio_pkg, also used by the DAC side.
REQ-026 Serial capture (shift register + 4-bit bit counter + done flag) SHALL be sub-module i2s_rx_shift; FSM, address and SRAM drive stay in adc_recorder.

Verification
REQ-027 Start=0x00010, end=0x00012, L=0x1234, R=0x1234 each frame -> three writes of 0x1234 at 0x10,0x11,0x12, o_done pulse once, o_last_pos=0x12.
REQ-028 With ADC_MONO_AVG_EN, L=0x7FFF, R=0x7FFF -> 0x7FFF written; L=0x8000, R=0x7FFF -> 0xFFFF; without macro, L=0x8000 -> 0x8000.
REQ-029 i_record dropped at bit 7 of right word of 2nd frame -> only 1 write, o_done pulses, o_last_pos=start.
REQ-030 i_rst_n pulsed low mid-left-word -> outputs at reset values immediately, no write, clean record from i_start_pos after re-arm.
REQ-031 i_record raised while i_ADCLRCK high (mid right word) -> first write occurs only after next full left+right frame.
REQ-032 start=0x00005, end=0x00003 -> single write at 0x05, then done.
